// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers system writes and hands bytes over one at a
// time on din/wr_en, pacing on tx_busy.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [7:0]        wr_data,
    input  logic              wr,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    input  logic              tx_busy
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic                push, pop;
    logic [ADDR_W:0]     count_nxt;

    // push is judged against last cycle's full, so a pop cannot make room this edge
    assign push = wr & ~full;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_din   <= '0;
            tx_wr_en <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                tx_din <= mem[rd_ptr];
            end
            tx_wr_en <= pop;
            count    <= count_nxt;
            full     <= (count_nxt == FULL_CNT);
            empty    <= (count_nxt == '0);
            // a dropped write outranks a simultaneous clear
            if (wr && full)   overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule
